// File: rtl/spu_focal_window.sv
// 3x3 focal window operator over a raster-order ready/valid stream: sum, min, max or range.
// Optional build macro SPU_FOCAL_NODATA_EN excludes NODATA cells from the reduction.
module spu_focal_window #(
  parameter int RASTER_W = 8,
  parameter int DATA_W   = 8,
  parameter int SUM_W    = DATA_W + 4
`ifdef SPU_FOCAL_NODATA_EN
  , parameter logic [DATA_W-1:0] NODATA = '1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_data,
  output logic              out_last
);

  localparam int COL_W = (RASTER_W > 2) ? $clog2(RASTER_W) : 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(RASTER_W - 1);

  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_rows;
  logic [1:0]        r_mode;
  logic              r_out_valid;
  logic [SUM_W-1:0]  r_out_data;
  logic              r_out_last;
  logic [DATA_W-1:0] r_lb0 [RASTER_W];
  logic [DATA_W-1:0] r_lb1 [RASTER_W];
  // Only the two older window columns are stored; the newest column is formed from the line buffers.
  logic [DATA_W-1:0] r_win [3][2];

  logic              w_accept;
  logic [COL_W-1:0]  w_col;
  logic [1:0]        w_rows;
  logic              w_produce;
  logic [DATA_W-1:0] w_newcol [3];
  logic [DATA_W-1:0] w_cell [9];
  logic [8:0]        w_use;
  logic [SUM_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;
  logic [SUM_W-1:0]  w_result;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_col     = in_sof ? '0 : r_col;
  assign w_rows    = in_sof ? 2'd0 : r_rows;
  assign w_produce = w_accept && (w_rows == 2'd2) && (w_col >= COL_W'(2));

  assign w_newcol[0] = r_lb1[w_col];
  assign w_newcol[1] = r_lb0[w_col];
  assign w_newcol[2] = in_data;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_cell[r*3 + 0] = r_win[r][0];
      w_cell[r*3 + 1] = r_win[r][1];
      w_cell[r*3 + 2] = w_newcol[r];
    end
  end

  always_comb begin
    w_use = '1;
`ifdef SPU_FOCAL_NODATA_EN
    for (int i = 0; i < 9; i++) begin
      w_use[i] = (w_cell[i] != NODATA);
    end
`endif
  end

  always_comb begin
    w_sum = '0;
    w_min = '1;
    w_max = '0;
    for (int i = 0; i < 9; i++) begin
      if (w_use[i]) begin
        w_sum = w_sum + SUM_W'(w_cell[i]);
        if (w_cell[i] < w_min) w_min = w_cell[i];
        if (w_cell[i] > w_max) w_max = w_cell[i];
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (r_mode)
      2'd0:    w_result = w_sum;
      2'd1:    w_result = SUM_W'(w_min);
      2'd2:    w_result = SUM_W'(w_max);
      default: w_result = SUM_W'(w_max - w_min);
    endcase
`ifdef SPU_FOCAL_NODATA_EN
    // Centre is cell 4; a NODATA centre or an all-NODATA window propagates NODATA.
    if (!w_use[4] || (w_use == 9'd0)) w_result = SUM_W'(NODATA);
`endif
  end

  // Storage is not reset; the row/column counters decide what is meaningful.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= in_data;
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_newcol[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_rows <= 2'd0;
      r_mode <= 2'd0;
    end else if (w_accept) begin
      if (in_sof) r_mode <= mode;
      if (in_eof) begin
        r_col  <= '0;
        r_rows <= 2'd0;
      end else if (w_col == COL_LAST) begin
        r_col  <= '0;
        r_rows <= (w_rows == 2'd2) ? 2'd2 : w_rows + 2'd1;
      end else begin
        r_col  <= w_col + COL_W'(1);
        r_rows <= w_rows;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_last  <= in_eof;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_spu_focal_window.sv
// Scoreboard bench for spu_focal_window: directed frames, expected windows queued, monitor pops on handshake.
module tb_spu_focal_window;
  localparam int W  = 8;
  localparam int DW = 8;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_eof = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  spu_focal_window #(.RASTER_W(W), .DATA_W(DW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  typedef struct packed {
    logic [SW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            img[8][8];
  int            rdy_mode = 0;
  int            rcnt = 0;
  int            n_pop = 0;
  logic [SW-1:0] first_d = '0;
  logic [SW-1:0] last_d = '0;

  // out_ready pattern changes just after the edge so it is stable at the sampling negedge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        rcnt++;
      end
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL in_ready_stall got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output got data=%0d last=%b want none", out_data, out_last);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            n_err++;
            $display("FAIL window_out got data=%0d last=%b want data=%0d last=%b",
                     out_data, out_last, e.d, e.l);
          end
          if (n_pop == 0) first_d = out_data;
          last_d = out_data;
          n_pop++;
        end
      end
    end
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [SW-1:0] model(int r, int c, int m);
    int s  = 0;
    int mn = 1 << 30;
    int mx = -1;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int v;
        bit use_v;
        v = img[r+dr][c+dc];
        use_v = 1'b1;
`ifdef SPU_FOCAL_NODATA_EN
        use_v = (v != 255);
`endif
        if (use_v) begin
          s += v;
          if (v < mn) mn = v;
          if (v > mx) mx = v;
        end
      end
    end
`ifdef SPU_FOCAL_NODATA_EN
    if (img[r][c] == 255 || mx < 0) return SW'(255);
`endif
    case (m)
      0: return SW'(s);
      1: return SW'(mn);
      2: return SW'(mx);
      default: return SW'(mx - mn);
    endcase
  endfunction

  task automatic push_windows(int m, int n_max);
    int n = 0;
    for (int r = 1; r <= 6; r++) begin
      for (int c = 1; c <= 6; c++) begin
        if (n < n_max) begin
          exp_t e;
          e.d = model(r, c, m);
          e.l = (r == 6) && (c == 6);
          q.push_back(e);
          n++;
        end
      end
    end
  endtask

  // Called and returns at a negedge; the beat is accepted at the intervening posedge.
  task automatic send_cell(int k, bit sof, int m);
    int g = 0;
    in_valid = 1'b1;
    in_data  = DW'(img[k/8][k%8]);
    in_sof   = sof;
    in_eof   = (k == 63);
    mode     = 2'(m);
    while (!in_ready) begin
      @(negedge clk);
      g++;
      if (g > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout got 0 want 1");
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic send_range(int k0, int k1, int m);
    for (int k = k0; k <= k1; k++) send_cell(k, (k == k0), m);
  endtask

  task automatic drain(int remain);
    int g = 0;
    while (q.size() > remain && g < 600) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (q.size() > remain) begin
      n_err++;
      $display("FAIL drain_timeout got %0d queued want %0d", q.size(), remain);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_img();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = 8*r + c;
  endtask

  initial begin
    int first_exp[4];
    int last_exp[4];
    first_exp = '{81, 0, 18, 18};
    last_exp  = '{486, 45, 63, 18};
    fill_img();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_in_ready", int'(in_ready), 1);

    for (int m = 0; m < 4; m++) begin
      n_pop = 0;
      push_windows(m, 36);
      send_range(0, 63, m);
      drain(0);
      check("frame_count", n_pop, 36);
      check("frame_first", int'(first_d), first_exp[m]);
      check("frame_last", int'(last_d), last_exp[m]);
    end

    rdy_mode = 1;
    n_pop = 0;
    push_windows(0, 36);
    send_range(0, 63, 0);
    drain(0);
    rdy_mode = 0;
    check("bp_count", n_pop, 36);
    check("bp_first", int'(first_d), 81);
    check("bp_last", int'(last_d), 486);

    // Abandoned partial frame (20 cells) then a resync sof frame
    n_pop = 0;
    q.push_back('{d: SW'(81), l: 1'b0});
    q.push_back('{d: SW'(90), l: 1'b0});
    send_range(0, 19, 0);
    push_windows(0, 36);
    send_range(0, 63, 0);
    drain(0);
    check("resync_count", n_pop, 38);
    check("resync_last", int'(last_d), 486);

    // Reset while an output is pending during row 4
    n_pop = 0;
    push_windows(0, 13);
    send_range(0, 33, 0);
    drain(1);
    rdy_mode = 2;
    @(negedge clk);
    send_cell(34, 1'b0, 0);
    check("pre_rst_out_valid", int'(out_valid), 1);
    check("pre_rst_out_data", int'(out_data), 9*25);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    q.delete();
    rdy_mode = 0;
    @(negedge clk);
    check("rst_popped", n_pop, 12);
    n_pop = 0;
    push_windows(0, 36);
    send_range(0, 63, 0);
    drain(0);
    check("post_rst_count", n_pop, 36);
    check("post_rst_first", int'(first_d), 81);
    check("post_rst_last", int'(last_d), 486);

`ifdef SPU_FOCAL_NODATA_EN
    img[0][0] = 255;
    n_pop = 0;
    push_windows(1, 36);
    send_range(0, 63, 1);
    drain(0);
    check("nodata_min_first", int'(first_d), 1);
    fill_img();
    img[1][1] = 255;
    n_pop = 0;
    push_windows(0, 36);
    send_range(0, 63, 0);
    drain(0);
    check("nodata_centre_first", int'(first_d), 255);
    fill_img();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
